// File: rtl/reg_readback_ser_pkg.sv
// Shared types and constants for the register readback serializer.
package reg_readback_ser_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int frame_len(
    input int width,
    input bit par
  );
    return width + 2 + (par ? 1 : 0);
  endfunction

endpackage

// File: rtl/reg_readback_ser_shifter.sv
// Readback shifter: shadow snapshot, bit index counter and bit select.
module reg_readback_ser_shifter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             step,
  input  logic [WIDTH-1:0] d,
  output logic             first_bit,
  output logic             next_bit,
  output logic             last,
  output logic             parity
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shadow;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      cnt    <= '0;
    end else if (capture) begin
      shadow <= d;
      cnt    <= CW'(WIDTH - 1);
    end else if (step) begin
      cnt    <= cnt - CW'(1);
    end
  end

  assign idx = cnt - CW'(1);

  // Bit to present after the current one, MSB first.
  always_comb begin
    next_bit = 1'b0;
    if (cnt != '0)
      next_bit = shadow[idx];
  end

  assign first_bit = shadow[WIDTH-1];
  assign last      = (cnt == '0);
  assign parity    = ^shadow;

endmodule

// File: rtl/reg_readback_ser.sv
// INIT register with framed serial readback; READBACK_PARITY_EN adds
// an even-parity bit between the last data bit and the stop bit.
module reg_readback_ser
  import reg_readback_ser_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = 4'b1011
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] di,
  output logic [WIDTH-1:0] q,
  input  logic             req,
  output logic             sdo,
  output logic             sframe,
  output logic             busy,
  output logic             done
);

  state_t state;
  logic   capture;
  logic   step;
  logic   first_bit;
  logic   next_bit;
  logic   last;
`ifdef READBACK_PARITY_EN
  logic   parity;
`endif

  assign capture = (state == S_IDLE) && req;
  assign step    = (state == S_DATA) && !last;

  reg_readback_ser_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .step     (step),
    .d        (q),
    .first_bit(first_bit),
    .next_bit (next_bit),
    .last     (last),
`ifdef READBACK_PARITY_EN
    .parity   (parity)
`else
    .parity   ()
`endif
  );

  always_ff @(posedge clk) begin
    if (rst)
      q <= INIT;
    else if (load)
      q <= di;
  end

  // Outputs are registered for the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      sdo    <= STOP_BIT;
      sframe <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            state  <= S_START;
            sdo    <= START_BIT;
            sframe <= 1'b1;
            busy   <= 1'b1;
          end
        end
        S_START: begin
          state <= S_DATA;
          sdo   <= first_bit;
        end
        S_DATA: begin
          if (last) begin
`ifdef READBACK_PARITY_EN
            state <= S_PAR;
            sdo   <= parity;
`else
            state <= S_STOP;
            sdo   <= STOP_BIT;
            done  <= 1'b1;
`endif
          end else begin
            sdo <= next_bit;
          end
        end
        S_PAR: begin
          state <= S_STOP;
          sdo   <= STOP_BIT;
          done  <= 1'b1;
        end
        S_STOP: begin
          state  <= S_IDLE;
          sdo    <= STOP_BIT;
          sframe <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          sdo    <= STOP_BIT;
          sframe <= 1'b0;
          busy   <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_readback_ser.sv
// Bench for reg_readback_ser: frame-list reference model plus
// directed and random steps.
module tb_reg_readback_ser;

  localparam int         W    = 4;
  localparam logic [3:0] INIT = 4'b1011;
`ifdef READBACK_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int         FL    = W + 2 + (PAR ? 1 : 0);
  localparam logic [7:0] FMASK = 8'((1 << FL) - 1);

  logic       clk;
  logic       rst;
  logic       load;
  logic [3:0] di;
  logic [3:0] q;
  logic       req;
  logic       sdo;
  logic       sframe;
  logic       busy;
  logic       done;

  reg_readback_ser #(
    .WIDTH(W),
    .INIT (INIT)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .di    (di),
    .q     (q),
    .req   (req),
    .sdo   (sdo),
    .sframe(sframe),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic sdo;
    logic sframe;
    logic busy;
    logic done;
  } obs_t;

  localparam obs_t IDLE_O = 4'b1000;

  obs_t        fq[$];
  obs_t        cur;
  logic [3:0]  mreg;
  logic [15:0] hist;
  int          tests;
  int          fails;

  task automatic chk(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] v);
    fq.push_back(4'b0110);
    for (int i = W - 1; i >= 0; i--)
      fq.push_back({v[i], 3'b110});
    if (PAR)
      fq.push_back({^v, 3'b110});
    fq.push_back(4'b1111);
  endtask

  task automatic step(
    input logic       r,
    input logic       l,
    input logic [3:0] d,
    input logic       rq
  );
    rst  = r;
    load = l;
    di   = d;
    req  = rq;
    @(posedge clk);
    if (r) begin
      fq.delete();
      cur  = IDLE_O;
      mreg = INIT;
    end else begin
      if (fq.size() > 0)
        cur = fq.pop_front();
      else if (!cur.busy && rq) begin
        push_frame(mreg);
        cur = fq.pop_front();
      end else
        cur = IDLE_O;
      if (l)
        mreg = d;
    end
    @(negedge clk);
    hist = {hist[14:0], sdo};
    chk("q", 8'(q), 8'(mreg));
    chk("sdo", 8'(sdo), 8'(cur.sdo));
    chk("sframe", 8'(sframe), 8'(cur.sframe));
    chk("busy", 8'(busy), 8'(cur.busy));
    chk("done", 8'(done), 8'(cur.done));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  logic [7:0] e;

  initial begin
    tests = 0;
    fails = 0;
    hist  = '0;
    cur   = IDLE_O;
    mreg  = INIT;
    rst   = 1'b1;
    load  = 1'b0;
    di    = '0;
    req   = 1'b0;

    step(1'b1, 1'b0, 4'h0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    chk("rst_q", 8'(q), 8'(INIT));
    chk("rst_sdo", 8'(sdo), 8'd1);
    chk("rst_busy", 8'(busy), 8'd0);

    step(1'b0, 1'b0, 4'h0, 1'b1);
    idle(FL - 1);
    e = PAR ? 8'b0101111 : 8'b010111;
    chk("frame_init", hist[7:0] & FMASK, e);
    chk("frame_init_done", 8'(done), 8'd1);
    idle(1);

    step(1'b0, 1'b1, 4'b0110, 1'b0);
    chk("load_q", 8'(q), 8'b0110);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    idle(FL - 1);
    e = PAR ? 8'b0011001 : 8'b001101;
    chk("frame_0110", hist[7:0] & FMASK, e);
    idle(1);

    step(1'b0, 1'b1, 4'b1011, 1'b0);
    idle(1);
    step(1'b0, 1'b1, 4'b0000, 1'b1);
    chk("same_cycle_q", 8'(q), 8'd0);
    idle(FL - 1);
    e = PAR ? 8'b0101111 : 8'b010111;
    chk("frame_snapshot", hist[7:0] & FMASK, e);
    idle(1);

    step(1'b0, 1'b1, 4'b0111, 1'b0);
    step(1'b0, 1'b0, 4'h0, 1'b1);
    idle(FL - 1);
    e = PAR ? 8'b0011111 : 8'b001111;
    chk("frame_0111", hist[7:0] & FMASK, e);

    for (int i = 0; i < 2 * (FL + 1); i++)
      step(1'b0, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < FL; i++)
      step(1'b0, (i == 2), 4'b1001, 1'(i % 2));
    idle(2);

    step(1'b0, 1'b0, 4'h0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 4'h0, 1'b0);
    chk("midrst_sdo", 8'(sdo), 8'd1);
    chk("midrst_sframe", 8'(sframe), 8'd0);
    chk("midrst_busy", 8'(busy), 8'd0);
    chk("midrst_done", 8'(done), 8'd0);
    chk("midrst_q", 8'(q), 8'(INIT));
    idle(FL);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 3) == 0),
           4'($urandom_range(0, 15)),
           1'($urandom_range(0, 2) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
